// File: rtl/trig_tx_arbiter.sv
// rtl/trig_tx_arbiter.sv - round-robin arbiter and 16-bit framer for the shared trigger TX path
//
// Purpose:
//   Several trigger TX channels share one fabric transmit path. Each channel
//   offers a timestamped trigger (ID, TAI seconds, 8 ns cycles). In IDLE the
//   arbiter grants one channel round-robin. It accepts the message in a
//   one-cycle ACCEPT state and then sends it as a framed stream of 16-bit
//   words. After each frame it holds the stream quiet for g_ifg cycles.
//
// Ports:
//   clk_sys_i        system clock
//   rst_n_i          asynchronous active-low reset
//   enable_i         arbitration enable (gates new grants only)
//   req_valid_i      per-channel message valid
//   req_ready_o      per-channel accept strobe (one cycle, one-hot)
//   req_id_i         16-bit trigger ID per channel
//   req_tai_i        32-bit TAI seconds per channel
//   req_cycles_i     28-bit cycle count per channel
//   src_dat_o        stream data word
//   src_valid_o      stream word valid
//   src_sop_o        first word of frame
//   src_eop_o        last word of frame
//   src_ready_i      sink ready
//   busy_o           arbiter not in IDLE
//   frames_sent_o    completed frame count (wraps)
//   seq_o            next sequence value (TRIG_ARB_SEQ_EN only)
//
// Build option:
//   TRIG_ARB_SEQ_EN  appends a 16-bit sequence word after the cycles word
//                    and adds the seq_o port.

module trig_tx_arbiter #(
  parameter int g_num_channels = 4,
  parameter int g_ifg          = 2
) (
  input  logic                          clk_sys_i,
  input  logic                          rst_n_i,
  input  logic                          enable_i,
  input  logic [g_num_channels-1:0]     req_valid_i,
  output logic [g_num_channels-1:0]     req_ready_o,
  input  logic [16*g_num_channels-1:0]  req_id_i,
  input  logic [32*g_num_channels-1:0]  req_tai_i,
  input  logic [28*g_num_channels-1:0]  req_cycles_i,
  output logic [15:0]                   src_dat_o,
  output logic                          src_valid_o,
  output logic                          src_sop_o,
  output logic                          src_eop_o,
  input  logic                          src_ready_i,
  output logic                          busy_o,
  output logic [31:0]                   frames_sent_o
`ifdef TRIG_ARB_SEQ_EN
  ,
  output logic [15:0]                   seq_o
`endif
);

  // Channel index width; kept at least 1 bit so a single-channel build works.
  localparam int c_iw = (g_num_channels > 1) ? $clog2(g_num_channels) : 1;

`ifdef TRIG_ARB_SEQ_EN
  localparam int c_words = 6;
`else
  localparam int c_words = 5;
`endif
  localparam int c_fw = 16 * c_words;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCEPT,
    S_SEND,
    S_GAP
  } state_t;

  state_t                    state_q;
  logic [c_iw-1:0]           rr_q;
  logic [c_iw-1:0]           grant_q;
  logic [g_num_channels-1:0] ready_q;
  logic [c_fw-1:0]           frame_q;
  logic [2:0]                idx_q;
  logic                      valid_q;
  logic                      sop_q;
  logic                      eop_q;
  logic [3:0]                gap_q;
  logic [31:0]               frames_q;
`ifdef TRIG_ARB_SEQ_EN
  logic [15:0]               seq_q;
`endif

  logic [c_iw-1:0]           grant_d;
  logic [g_num_channels-1:0] ready_d;
  logic [c_fw-1:0]           frame_d;
  logic [15:0]               sel_id;
  logic [31:0]               sel_tai;
  logic [27:0]               sel_cyc;

  // Round-robin pick: the lowest requesting index above rr_q wins. If there
  // is none, the search wraps to the lowest requesting index overall. The
  // loop runs downwards, so the last match seen is the lowest index.
  logic            hi_found;
  logic [c_iw-1:0] hi_idx;
  logic [c_iw-1:0] lo_idx;

  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int k = g_num_channels - 1; k >= 0; k--) begin
      if (req_valid_i[k]) begin
        lo_idx = c_iw'(k);
        if (k > int'(rr_q)) begin
          hi_found = 1'b1;
          hi_idx   = c_iw'(k);
        end
      end
    end
    grant_d = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    ready_d = '0;
    for (int k = 0; k < g_num_channels; k++) begin
      ready_d[k] = (grant_d == c_iw'(k));
    end
  end

  // Message fields of the granted channel, captured at the end of ACCEPT.
  always_comb begin
    sel_id  = '0;
    sel_tai = '0;
    sel_cyc = '0;
    for (int k = 0; k < g_num_channels; k++) begin
      if (grant_q == c_iw'(k)) begin
        sel_id  = req_id_i[16*k +: 16];
        sel_tai = req_tai_i[32*k +: 32];
        sel_cyc = req_cycles_i[28*k +: 28];
      end
    end
  end

  // The whole frame is held in a shift register with w0 in the top 16 bits.
  // Each accepted word shifts in zeros, so the data bus reads 0 between frames.
`ifdef TRIG_ARB_SEQ_EN
  assign frame_d = {sel_id, sel_tai, 4'h0, sel_cyc, seq_q};
`else
  assign frame_d = {sel_id, sel_tai, 4'h0, sel_cyc};
`endif

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      rr_q     <= c_iw'(g_num_channels - 1);
      grant_q  <= '0;
      ready_q  <= '0;
      frame_q  <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      gap_q    <= '0;
      frames_q <= '0;
`ifdef TRIG_ARB_SEQ_EN
      seq_q    <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enable_i && (|req_valid_i)) begin
            grant_q <= grant_d;
            rr_q    <= grant_d;
            ready_q <= ready_d;
            state_q <= S_ACCEPT;
          end
        end

        S_ACCEPT: begin
          // The requester holds its data through this cycle. The capture
          // does not depend on its valid bit.
          ready_q <= '0;
          frame_q <= frame_d;
          idx_q   <= '0;
          valid_q <= 1'b1;
          sop_q   <= 1'b1;
          eop_q   <= 1'b0;
          state_q <= S_SEND;
        end

        S_SEND: begin
          if (src_ready_i) begin
            frame_q <= frame_q << 16;
            sop_q   <= 1'b0;
            if (idx_q == 3'(c_words - 1)) begin
              valid_q  <= 1'b0;
              eop_q    <= 1'b0;
              frames_q <= frames_q + 32'd1;
`ifdef TRIG_ARB_SEQ_EN
              seq_q    <= seq_q + 16'd1;
`endif
              if (g_ifg > 0) begin
                gap_q   <= 4'(g_ifg - 1);
                state_q <= S_GAP;
              end else begin
                state_q <= S_IDLE;
              end
            end else begin
              idx_q <= idx_q + 3'd1;
              eop_q <= (idx_q == 3'(c_words - 2));
            end
          end
        end

        S_GAP: begin
          if (gap_q == 4'd0) begin
            state_q <= S_IDLE;
          end else begin
            gap_q <= gap_q - 4'd1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o   = ready_q;
  assign src_dat_o     = frame_q[c_fw-1 -: 16];
  assign src_valid_o   = valid_q;
  assign src_sop_o     = sop_q;
  assign src_eop_o     = eop_q;
  assign busy_o        = (state_q != S_IDLE);
  assign frames_sent_o = frames_q;
`ifdef TRIG_ARB_SEQ_EN
  assign seq_o         = seq_q;
`endif

endmodule

// File: tb/tb_trig_tx_arbiter.sv
// tb/tb_trig_tx_arbiter.sv - self-checking bench for trig_tx_arbiter

module tb_trig_tx_arbiter;

  localparam int N   = 4;
  localparam int IFG = 2;
`ifdef TRIG_ARB_SEQ_EN
  localparam int W = 6;
`else
  localparam int W = 5;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            enable;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [16*N-1:0] req_id;
  logic [32*N-1:0] req_tai;
  logic [28*N-1:0] req_cyc;
  logic [15:0]     src_dat;
  logic            src_valid;
  logic            src_sop;
  logic            src_eop;
  logic            src_ready;
  logic            busy;
  logic [31:0]     frames_sent;
`ifdef TRIG_ARB_SEQ_EN
  logic [15:0]     seq;
`endif

  always #5 clk = ~clk;

  trig_tx_arbiter #(.g_num_channels(N), .g_ifg(IFG)) dut (
    .clk_sys_i    (clk),
    .rst_n_i      (rst_n),
    .enable_i     (enable),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_id_i     (req_id),
    .req_tai_i    (req_tai),
    .req_cycles_i (req_cyc),
    .src_dat_o    (src_dat),
    .src_valid_o  (src_valid),
    .src_sop_o    (src_sop),
    .src_eop_o    (src_eop),
    .src_ready_i  (src_ready),
    .busy_o       (busy),
    .frames_sent_o(frames_sent)
`ifdef TRIG_ARB_SEQ_EN
    ,
    .seq_o        (seq)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Requester and sink model state
  int          pend[N];
  logic [15:0] m_id[N];
  logic [31:0] m_tai[N];
  logic [27:0] m_cyc[N];
  int          hs_ch;
  int          model_rr;
  int          model_frames;
  int          model_seq;
  logic [15:0] exp_q[$];
  int          pos;
  int          rdy_mode;
  int          stall_left;
  int          w2_cycles;
  logic        stall_prev;
  logic [18:0] stall_snap;
  int          grant_log[$];
  int          ready_cyc[$];
  int          sop_cyc[$];
  int          eop_cyc[$];
  logic [15:0] word_dat[$];
  logic        busy_log[256];

  function automatic int rr_pick(logic [N-1:0] v, int last);
    for (int i = 1; i <= N; i++) begin
      if (v[(last + i) % N]) return (last + i) % N;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      req_valid[k]         = (pend[k] > 0);
      req_id[16*k +: 16]   = m_id[k];
      req_tai[32*k +: 32]  = m_tai[k];
      req_cyc[28*k +: 28]  = m_cyc[k];
    end
  endtask

  task automatic randomize_msg(int k);
    m_id[k]  = 16'($urandom);
    m_tai[k] = $urandom;
    m_cyc[k] = 28'($urandom);
  endtask

  task automatic push_frame(int k);
    exp_q.push_back(m_id[k]);
    exp_q.push_back(m_tai[k][31:16]);
    exp_q.push_back(m_tai[k][15:0]);
    exp_q.push_back({4'h0, m_cyc[k][27:16]});
    exp_q.push_back(m_cyc[k][15:0]);
`ifdef TRIG_ARB_SEQ_EN
    exp_q.push_back(16'(model_seq));
`endif
    model_seq++;
  endtask

  task automatic model_clear();
    for (int k = 0; k < N; k++) pend[k] = 0;
    hs_ch        = -1;
    model_rr     = N - 1;
    model_frames = 0;
    model_seq    = 0;
    pos          = 0;
    stall_prev   = 1'b0;
    exp_q.delete();
    drive();
  endtask

  task automatic clear_logs();
    grant_log.delete();
    ready_cyc.delete();
    sop_cyc.delete();
    eop_cyc.delete();
    word_dat.delete();
    w2_cycles = 0;
  endtask

  // One clock cycle. Outputs are sampled 1 time unit after the rising edge,
  // and inputs for the new cycle are applied at the same point.
  task automatic tick();
    logic [N-1:0] v_seen;
    logic         e_seen;
    logic [N-1:0] exp_vec;
    logic [15:0]  d;
    int           e;
    @(posedge clk);
    #1;
    cyc++;
    v_seen = req_valid;
    e_seen = enable;
    if (hs_ch >= 0) begin
      pend[hs_ch]--;
      randomize_msg(hs_ch);
      hs_ch = -1;
      drive();
    end
    if (rdy_mode == 1) begin
      src_ready = ($urandom_range(0, 3) != 0);
    end else if (rdy_mode == 2) begin
      src_ready = !(stall_left > 0 && src_valid && pos == 2);
      if (!src_ready) stall_left--;
    end else begin
      src_ready = 1'b1;
    end
    busy_log[cyc % 256] = busy;

    checks++;
    if (frames_sent !== 32'(model_frames)) begin
      errors++;
      $display("FAIL frames_sent got %0d want %0d (cycle %0d)", frames_sent, model_frames, cyc);
    end
`ifdef TRIG_ARB_SEQ_EN
    checks++;
    if (seq !== 16'(model_frames)) begin
      errors++;
      $display("FAIL seq_o got %0d want %0d", seq, model_frames);
    end
`endif
    if (stall_prev) begin
      checks++;
      if ({src_valid, src_sop, src_eop, src_dat} !== stall_snap) begin
        errors++;
        $display("FAIL stall_hold got %h want %h", {src_valid, src_sop, src_eop, src_dat}, stall_snap);
      end
    end
    if (req_ready !== '0) begin
      e = rr_pick(v_seen, model_rr);
      exp_vec = '0;
      if (e >= 0) exp_vec[e] = 1'b1;
      checks++;
      if (!e_seen || e < 0 || req_ready !== exp_vec) begin
        errors++;
        $display("FAIL grant got %b want %b enable %0b", req_ready, exp_vec, e_seen);
      end
      if (e >= 0) begin
        model_rr = e;
        hs_ch    = e;
        push_frame(e);
        grant_log.push_back(e);
        ready_cyc.push_back(cyc);
      end
    end
    if (src_valid && pos == 2 && exp_q.size() > 0) w2_cycles++;
    if (src_valid && src_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL word unexpected got %h want none", src_dat);
      end else begin
        d = exp_q.pop_front();
        if (src_dat !== d || src_sop !== (pos == 0) || src_eop !== (pos == W - 1)) begin
          errors++;
          $display("FAIL word[%0d] got %h sop %b eop %b want %h sop %b eop %b",
                   pos, src_dat, src_sop, src_eop, d, (pos == 0), (pos == W - 1));
        end
      end
      word_dat.push_back(src_dat);
      if (pos == 0) sop_cyc.push_back(cyc);
      if (pos == W - 1) eop_cyc.push_back(cyc);
      pos++;
      if (pos == W) begin
        pos = 0;
        model_frames++;
      end
    end
    stall_prev = src_valid && !src_ready;
    stall_snap = {src_valid, src_sop, src_eop, src_dat};
  endtask

  function automatic bit all_idle();
    for (int k = 0; k < N; k++) if (pend[k] != 0) return 1'b0;
    return (hs_ch < 0) && (exp_q.size() == 0) && !busy && (req_ready == '0);
  endfunction

  task automatic drain(int budget, string tag);
    int n = 0;
    while (!all_idle() && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (!all_idle()) begin
      errors++;
      $display("FAIL %s drain timeout got busy want idle after %0d cycles", tag, budget);
    end
  endtask

  task automatic load(int k, logic [15:0] id, logic [31:0] tai, logic [27:0] cy, int n);
    m_id[k]  = id;
    m_tai[k] = tai;
    m_cyc[k] = cy;
    pend[k]  = n;
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_clear();
    repeat (2) tick();
    checks++;
    if (req_ready !== '0) begin errors++; $display("FAIL reset_ready got %b want 0", req_ready); end
    checks++;
    if ({src_valid, src_sop, src_eop} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b want 000", {src_valid, src_sop, src_eop});
    end
    checks++;
    if (src_dat !== 16'h0) begin errors++; $display("FAIL reset_dat got %h want 0", src_dat); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int t0;
    logic [15:0] ref_w[5];
    ref_w[0] = 16'h000B; ref_w[1] = 16'h1234; ref_w[2] = 16'h5678;
    ref_w[3] = 16'h0ABC; ref_w[4] = 16'hDEF1;
    clear_logs();
    load(1, 16'h000B, 32'h12345678, 28'hABCDEF1, 1);
    t0 = cyc;
    drain(100, "single");
    checks++;
    if (grant_log.size() != 1 || ready_cyc[0] != t0 + 1) begin
      errors++; $display("FAIL single_latency got ready at %0d want %0d", ready_cyc.size() ? ready_cyc[0] : -1, t0 + 1);
    end
    checks++;
    if (sop_cyc.size() != 1 || sop_cyc[0] != t0 + 2) begin
      errors++; $display("FAIL single_sop got %0d want %0d", sop_cyc.size() ? sop_cyc[0] : -1, t0 + 2);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (word_dat.size() <= i || word_dat[i] !== ref_w[i]) begin
        errors++; $display("FAIL single_word%0d got %h want %h", i, word_dat.size() > i ? word_dat[i] : 16'hx, ref_w[i]);
      end
    end
    checks++;
    if (frames_sent !== 32'd1) begin errors++; $display("FAIL single_count got %0d want 1", frames_sent); end
  endtask

  task automatic test_all_four();
    int want[5];
    want[0] = 0; want[1] = 1; want[2] = 2; want[3] = 3; want[4] = 0;
    do_reset();
    clear_logs();
    for (int k = 0; k < N; k++) randomize_msg(k);
    pend[0] = 2; pend[1] = 1; pend[2] = 1; pend[3] = 1;
    drive();
    drain(300, "all_four");
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (grant_log.size() <= i || grant_log[i] != want[i]) begin
        errors++; $display("FAIL rr_order[%0d] got %0d want %0d", i, grant_log.size() > i ? grant_log[i] : -1, want[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    clear_logs();
    rdy_mode   = 2;
    stall_left = 3;
    load(2, 16'h0C0D, 32'hCAFE5678, 28'h1234567, 1);
    drain(100, "backpressure");
    rdy_mode = 0;
    checks++;
    if (w2_cycles != 4) begin errors++; $display("FAIL bp_hold got %0d cycles want 4", w2_cycles); end
    checks++;
    if (word_dat.size() != W) begin errors++; $display("FAIL bp_count got %0d words want %0d", word_dat.size(), W); end
    checks++;
    if (word_dat.size() > 3 && (word_dat[2] !== 16'h5678 || word_dat[3] !== 16'h0123)) begin
      errors++; $display("FAIL bp_words got %h %h want 5678 0123", word_dat[2], word_dat[3]);
    end
  endtask

  task automatic test_gap();
    int e;
    do_reset();
    clear_logs();
    randomize_msg(0);
    randomize_msg(1);
    pend[0] = 1; pend[1] = 1;
    drive();
    drain(100, "gap");
    checks++;
    if (eop_cyc.size() < 2 || ready_cyc.size() < 2 || sop_cyc.size() < 2) begin
      errors++; $display("FAIL gap_frames got %0d frames want 2", eop_cyc.size());
    end else begin
      e = eop_cyc[0];
      checks++;
      if (ready_cyc[1] != e + IFG + 2) begin
        errors++; $display("FAIL gap_accept got %0d want %0d", ready_cyc[1], e + IFG + 2);
      end
      checks++;
      if (sop_cyc[1] != e + IFG + 3) begin
        errors++; $display("FAIL gap_sop got %0d want %0d", sop_cyc[1], e + IFG + 3);
      end
      checks++;
      if (busy_log[(e + 1) % 256] !== 1'b1 || busy_log[(e + IFG + 1) % 256] !== 1'b0) begin
        errors++; $display("FAIL gap_busy got %b%b want 10", busy_log[(e + 1) % 256], busy_log[(e + IFG + 1) % 256]);
      end
    end
  endtask

  task automatic test_enable();
    int n = 0;
    do_reset();
    clear_logs();
    randomize_msg(0);
    randomize_msg(1);
    pend[0] = 1; pend[1] = 1;
    drive();
    while (word_dat.size() < 2 && n < 30) begin
      tick();
      n++;
    end
    enable = 1'b0;
    repeat (25) tick();
    checks++;
    if (grant_log.size() != 1 || frames_sent !== 32'd1 || pend[1] != 1) begin
      errors++; $display("FAIL enable_block got %0d grants %0d frames want 1 1", grant_log.size(), frames_sent);
    end
    enable = 1'b1;
    drain(100, "enable");
    checks++;
    if (grant_log.size() != 2 || grant_log[1] != 1) begin
      errors++; $display("FAIL enable_resume got %0d grants want 2 ending ch1", grant_log.size());
    end
  endtask

  task automatic test_random();
    int posts = 0;
    int k;
    clear_logs();
    rdy_mode = 1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        k = $urandom_range(0, N - 1);
        if (pend[k] < 3) begin
          if (pend[k] == 0 && hs_ch != k) randomize_msg(k);
          pend[k]++;
          posts++;
          drive();
        end
      end
      enable = ($urandom_range(0, 9) != 0);
      tick();
    end
    enable = 1'b1;
    drain(3000, "random");
    rdy_mode = 0;
    checks++;
    if (grant_log.size() != posts) begin
      errors++; $display("FAIL random_grants got %0d want %0d", grant_log.size(), posts);
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    do_reset();
    clear_logs();
    randomize_msg(2);
    pend[2] = 1;
    drive();
    while (word_dat.size() < 3 && n < 30) begin
      tick();
      n++;
    end
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({src_valid, src_sop, src_eop, src_dat, busy, req_ready} !== '0 || frames_sent !== 32'd0) begin
      errors++; $display("FAIL async_reset got valid %b eop %b dat %h busy %b count %0d want all 0",
                         src_valid, src_eop, src_dat, busy, frames_sent);
    end
    model_clear();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    clear_logs();
    for (int k = 0; k < N; k++) randomize_msg(k);
    pend[0] = 3; pend[1] = 1; pend[2] = 1; pend[3] = 1;
    drive();
    drain(400, "post_reset");
    checks++;
    if (grant_log.size() == 0 || grant_log[0] != 0) begin
      errors++; $display("FAIL rr_restart got %0d want 0", grant_log.size() ? grant_log[0] : -1);
    end
`ifdef TRIG_ARB_SEQ_EN
    for (int f = 0; f < 3; f++) begin
      checks++;
      if (word_dat.size() <= 6 * f + 5 || word_dat[6 * f + 5] !== 16'(f)) begin
        errors++; $display("FAIL seq_word%0d got %h want %h", f, word_dat.size() > 6 * f + 5 ? word_dat[6 * f + 5] : 16'hx, 16'(f));
      end
    end
`endif
  endtask

  initial begin
    rst_n      = 1'b0;
    enable     = 1'b1;
    src_ready  = 1'b1;
    rdy_mode   = 0;
    stall_left = 0;
    for (int k = 0; k < N; k++) begin
      m_id[k] = '0; m_tai[k] = '0; m_cyc[k] = '0;
    end
    model_clear();
    clear_logs();
    test_reset();
    test_single();
    test_all_four();
    test_backpressure();
    test_gap();
    test_enable();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trig_tx_arbiter.md
Name: trig_tx_arbiter

Overview:
- Shares the single WR fabric trigger-message transmit path between g_num_channels trigger TX channels.
- Each channel offers a timestamped trigger (ID, TAI seconds, cycles) over a valid/ready handshake.
- The arbiter picks one channel by round-robin, accepts the message, then serialises it as a 5-word, 16-bit framed stream toward the fabric source. It enforces an inter-frame gap between messages.
- Sits between the per-channel trigger TX cores and the fabric mux in the trigger distribution core.

Parameters:
g_num_channels, 4, number of requesting TX channels (1..16)
g_ifg, 2, idle cycles inserted after each frame's EOP word (0..15)

Ports:
clk_sys_i  in  1  system clock
rst_n_i  in  1  asynchronous, active-low reset
enable_i  in  1  arbitration enable
req_valid_i  in  g_num_channels  per-channel message valid
req_ready_o  out  g_num_channels  per-channel accept strobe
req_id_i  in  16*g_num_channels  trigger ID, channel k at [16k+15:16k]
req_tai_i  in  32*g_num_channels  TAI seconds, channel k at [32k+31:32k]
req_cycles_i  in  28*g_num_channels  8 ns cycle count, channel k at [28k+27:28k]
src_dat_o  out  16  stream data word
src_valid_o  out  1  stream word valid
src_sop_o  out  1  first word of frame
src_eop_o  out  1  last word of frame
src_ready_i  in  1  sink ready; word transfers when valid and ready
busy_o  out  1  high in any state other than IDLE
frames_sent_o  out  32  count of completed frames, wraps at 2^32

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, rr pointer=g_num_channels-1.
  - All outputs 0, frames_sent_o=0.
- FSM states: IDLE, ACCEPT, SEND, GAP.
- IDLE:
  - If enable_i=1 and req_valid_i≠0, grant the first set bit strictly after the rr pointer, searching cyclically. Register the grant; rr pointer := granted index.
  - Go to ACCEPT.
- ACCEPT (1 cycle):
  - req_ready_o[grant]=1; all other bits are 0.
  - Latch that channel's id/tai/cycles at the end of the cycle. Go to SEND with word index 0.
- Requester rules:
  - Must hold valid and data stable until req_ready_o is seen.
  - Withdrawing valid before that is illegal.
  - The arbiter latches regardless of valid during ACCEPT.
- SEND:
  - src_valid_o=1.
  - Word order: w0=id, w1=tai[31:16], w2=tai[15:0], w3={4'h0,cycles[27:16]}, w4=cycles[15:0].
  - src_sop_o=1 only on w0; src_eop_o=1 only on the last word.
  - Word index advances only when src_ready_i=1. While ready is low, data, sop and eop hold stable.
  - On the last word with ready=1: frames_sent_o increments. Go to GAP if g_ifg>0, else IDLE.
- GAP: src_valid_o=0 for exactly g_ifg cycles, then IDLE.
- Latency: req_valid_i rising in IDLE at cycle 0 → req_ready_o at cycle 1 → SOP word at cycle 2. The minimum frame period is 5+g_ifg+2 cycles.
- enable_i=0:
  - Blocks new grants in IDLE only.
  - A frame in ACCEPT, SEND or GAP completes normally.
- Simultaneous requests are served in rotating order. No channel gets a second grant while another valid channel is waiting.
- With g_num_channels=1, the single channel is always granted.
- Async reset mid-frame aborts the frame immediately. No EOP is emitted, and all outputs and counters return to reset values.

Optional Feature:
- Macro: TRIG_ARB_SEQ_EN.
- When defined:
  - A 16-bit sequence word is appended after w4, making frames 6 words with EOP on w5.
  - The sequence counter resets to 0 and increments after each completed frame, wrapping 0xFFFF→0x0000.
  - Port seq_o (out, 16) shows the next sequence value.
- When undefined: frames are 5 words, and neither the seq_o port nor the counter exists.

Test Plan:
- Single request: ch1 id=0x000B, tai=0x12345678, cycles=0xABCDEF1, src_ready_i=1 → req_ready_o=4'b0010 at cycle 1, then words 0x000B, 0x1234, 0x5678, 0x0ABC, 0xDEF1 with sop on word 0 and eop on word 4; frames_sent_o=1.
- All four channels valid at once after reset → grant order 0,1,2,3; then 0 again if it is still requesting.
- Backpressure: src_ready_i low for 3 cycles on w2 → w2 held stable 4 cycles, no word lost or duplicated; then normal completion.
- Gap check, g_ifg=2: two back-to-back requests → exactly 2 cycles of src_valid_o=0 after EOP before the IDLE→ACCEPT sequence.
- enable_i dropped during SEND w1 → current frame completes; no further req_ready_o while enable is low; pending request served after re-enable.
- rst_n_i asserted at w3 → outputs 0 asynchronously; after release, frames_sent_o=0 and rr restarts at channel 0. With TRIG_ARB_SEQ_EN, also: three frames carry seq 0, 1, 2 in word 5.
